compound_accum_unit: RTL

COMPOUND_ACCUM_UNIT -- requirements
Module: compound_accum_unit

---
 rtl/compound_accum_pkg.sv | 32 +++
 rtl/compound_accum_div.sv | 59 +++++
 rtl/compound_accum_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/compound_accum_pkg.sv
// Shared types for the compound-assignment accumulator: op codes, FSM states
// and the DIV/MOD accept-to-completion latency.
package compound_accum_pkg;

  typedef enum logic [3:0] {
    OP_SET  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_MUL  = 4'd3,
    OP_DIV  = 4'd4,
    OP_MOD  = 4'd5,
    OP_AND  = 4'd6,
    OP_OR   = 4'd7,
    OP_XOR  = 4'd8,
    OP_SHL  = 4'd9,
    OP_SHR  = 4'd10,
    OP_ASHL = 4'd11,
    OP_ASHR = 4'd12
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One quotient bit per cycle plus the DONE cycle.
  function automatic int div_latency(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/compound_accum_div.sv
// Iterative restoring unsigned divider: one quotient bit per cycle, WIDTH cycles.
// quotient_o/remainder_o carry the final result in the cycle done_o is high.
module compound_accum_div #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             done_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dsr_q;
  logic [WIDTH-1:0] rem_d, quo_d;
  logic [WIDTH:0]   partial, diff;
  logic             q_bit;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  always_comb begin
    partial = {rem_q, quo_q[WIDTH-1]};
    diff    = partial - {1'b0, dsr_q};
    q_bit   = ~diff[WIDTH];
    rem_d   = q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
    quo_d   = {quo_q[WIDTH-2:0], q_bit};
  end

  assign quotient_o  = quo_d;
  assign remainder_o = rem_d;
  assign done_o      = busy_q && (cnt_q == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= CNT_W'(WIDTH);
      rem_q  <= '0;
      quo_q  <= dividend_i;
      dsr_q  <= divisor_i;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/compound_accum_unit.sv
// Accumulator applying C-style compound assignments (acc op= operand).
// Define COMPOUND_ACCUM_DIV_EN to build the iterative divider for DIV/MOD.
module compound_accum_unit
  import compound_accum_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] operand,
  output logic             out_valid,
  output logic [WIDTH-1:0] acc,
  output logic             err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;
  logic             accept, start_div, div_done;
  op_e              op_cur;

  assign accept = in_valid && in_ready;
  assign op_cur = op_e'(op);

`ifdef COMPOUND_ACCUM_DIV_EN
  logic [WIDTH-1:0] div_quo, div_rem;
  logic             is_mod_q, is_mod_d;

  compound_accum_div #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_div),
    .dividend_i (acc_q),
    .divisor_i  (operand),
    .quotient_o (div_quo),
    .remainder_o(div_rem),
    .done_o     (div_done)
  );
`else
  assign div_done = 1'b0;
`endif

  // Datapath next state.
  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    err_d       = 1'b0;
    start_div   = 1'b0;
`ifdef COMPOUND_ACCUM_DIV_EN
    is_mod_d    = is_mod_q;
`endif
    if (accept) begin
      out_valid_d = 1'b1;
      case (op_cur)
        OP_SET:          acc_d = operand;
        OP_ADD:          acc_d = acc_q + operand;
        OP_SUB:          acc_d = acc_q - operand;
        OP_MUL:          acc_d = acc_q * operand;
        OP_AND:          acc_d = acc_q & operand;
        OP_OR:           acc_d = acc_q | operand;
        OP_XOR:          acc_d = acc_q ^ operand;
        OP_SHL, OP_ASHL: acc_d = acc_q << operand;
        OP_SHR:          acc_d = acc_q >> operand;
        OP_ASHR:         acc_d = $unsigned($signed(acc_q) >>> operand);
`ifdef COMPOUND_ACCUM_DIV_EN
        OP_DIV, OP_MOD: begin
          // Divide by zero finishes immediately: DIV saturates, MOD keeps acc.
          if (operand == '0) begin
            if (op_cur == OP_DIV) acc_d = '1;
          end else begin
            out_valid_d = 1'b0;
            start_div   = 1'b1;
            is_mod_d    = (op_cur == OP_MOD);
          end
        end
`endif
        default:         err_d = 1'b1;
      endcase
    end
`ifdef COMPOUND_ACCUM_DIV_EN
    if (state_q == ST_DIV && div_done) begin
      acc_d       = is_mod_q ? div_rem : div_quo;
      out_valid_d = 1'b1;
    end
`endif
  end

  // FSM: state register.
  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_div) state_d = ST_DIV;
      ST_DIV:  if (div_done)  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    in_ready = (state_q == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef COMPOUND_ACCUM_DIV_EN
      is_mod_q    <= 1'b0;
`endif
    end else begin
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
`ifdef COMPOUND_ACCUM_DIV_EN
      is_mod_q    <= is_mod_d;
`endif
    end
  end

  assign acc       = acc_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

endmodule
